player_move_ctrl: RTL and testbench

- Front end of the player movement path: takes the four raw board push-buttons and turns them into clean, single-cycle move strobes.
- Its up/down/left/right outputs drive the player position stage directly, which applies one 15-pixel step per strobe.
- Stages, in order: 2-FF synchronisation, per-button debounce, opposite-direction cancellation, then per-axis press/auto-repeat state machines.
- Horizontal and vertical axes are handled independently.

---
 rtl/player_move_ctrl.sv | 179 +++++++++++++++++
 tb/tb_player_move_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Push-button front end: 2-FF sync, per-button debounce, opposite-direction cancel,
// then per-axis press/auto-repeat FSMs producing single-cycle move strobes.

module player_move_axis #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic strb_a_o,
  output logic strb_b_o
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          dir_q;
  logic          strb_a_q;
  logic          strb_b_q;
  logic          req;
  logic          req_dir;

  // req_a/req_b are already mutually exclusive; dir 1 selects b.
  assign req     = req_a_i | req_b_i;
  assign req_dir = req_b_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      dir_q    <= 1'b0;
      strb_a_q <= 1'b0;
      strb_b_q <= 1'b0;
    end else begin
      strb_a_q <= 1'b0;
      strb_b_q <= 1'b0;
      if (!enable_i || !req) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else if (state_q == IDLE || req_dir != dir_q) begin
        strb_a_q <= ~req_dir;
        strb_b_q <= req_dir;
        dir_q    <= req_dir;
        timer_q  <= '0;
        state_q  <= DELAY;
      end else if (state_q == DELAY) begin
        if (timer_q == DELAY_LAST) begin
          strb_a_q <= ~dir_q;
          strb_b_q <= dir_q;
          timer_q  <= '0;
          state_q  <= REPEAT;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end else begin
        if (timer_q == PERIOD_LAST) begin
          strb_a_q <= ~dir_q;
          strb_b_q <= dir_q;
          timer_q  <= '0;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  assign strb_a_o = strb_a_q;
  assign strb_b_o = strb_b_q;
endmodule

module player_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic enable,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]         btn_raw;
  logic [3:0]         sync1_q;
  logic [3:0]         sync2_q;
  logic [3:0]         lvl_q;
  logic [3:0]         lvl_d;
  logic [3:0][CW-1:0] cnt_q;
  logic [3:0][CW-1:0] cnt_d;
  logic               held_q;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      held_q  <= |lvl_q;
    end
  end

  logic up_req;
  logic down_req;
  logic left_req;
  logic right_req;

  assign up_req    = lvl_q[0] & ~lvl_q[1];
  assign down_req  = lvl_q[1] & ~lvl_q[0];
  assign left_req  = lvl_q[2] & ~lvl_q[3];
  assign right_req = lvl_q[3] & ~lvl_q[2];

  player_move_axis #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_vert (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(enable),
    .req_a_i (up_req),
    .req_b_i (down_req),
    .strb_a_o(up),
    .strb_b_o(down)
  );

  player_move_axis #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_horz (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(enable),
    .req_a_i (left_req),
    .req_b_i (right_req),
    .strb_a_o(left),
    .strb_b_o(right)
  );

  assign held = held_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Strobe vector order {up,down,left,right}; times are posedge counts sampled on the falling edge.

module tb_player_move_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic enable = 1'b1;
  logic up, down, left, right, held;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;
  exp_t exp_q[$];

  player_move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .enable   (enable),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .held     (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected strobes kept sorted by cycle; coinciding axes merge into one entry.
  task automatic expect_strobe(input int c, input logic [3:0] v);
    int   i;
    exp_t e;
    for (i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == c) begin
        e = exp_q[i];
        e.vec = e.vec | v;
        exp_q[i] = e;
        return;
      end
      if (exp_q[i].cyc > c) break;
    end
    e.cyc = c;
    e.vec = v;
    exp_q.insert(i, e);
  endtask

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [3:0] vec;
    exp_t       e;
    vec = {up, down, left, right};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_strobe: expected %b at cyc %0d, not seen", e.vec, e.cyc);
    end
    if (vec != 4'b0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        if (e.vec !== vec) begin
          errors++;
          $display("FAIL strobe_value at cyc %0d: got %b want %b", cyc, vec, e.vec);
        end
      end else begin
        errors++;
        $display("FAIL unexpected_strobe at cyc %0d: got %b want 0000", cyc, vec);
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: cyc %0d reached without completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int r;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {1'b0, up, down, left, right}, 5'b0);
    chk("reset_held", {4'b0, held}, 5'b0);
    rst_n = 1'b1;
    wait_to(cyc + 5);

    // Single press: exactly one up strobe, held follows debounced level by one cycle
    k = cyc;
    btn_up = 1'b1;
    expect_strobe(k + 7, 4'b1000);
    wait_to(k + 6);  chk("t1_held_before", {4'b0, held}, 5'b0);
    wait_to(k + 7);  chk("t1_held_rise", {4'b0, held}, 5'b1);
    wait_to(k + 8);  btn_up = 1'b0;
    wait_to(k + 14); chk("t1_held_still", {4'b0, held}, 5'b1);
    wait_to(k + 15); chk("t1_held_fall", {4'b0, held}, 5'b0);
    wait_to(k + 30);

    // Auto-repeat: t0, +10, then every 5
    k = cyc;
    btn_right = 1'b1;
    expect_strobe(k + 7, 4'b0001);
    for (int c = 17; c <= 37; c += 5) expect_strobe(k + c, 4'b0001);
    wait_to(k + 35); btn_right = 1'b0;
    wait_to(k + 55);

    // Glitch of 3 samples: rejected
    k = cyc;
    btn_left = 1'b1;
    wait_to(k + 3);  btn_left = 1'b0;
    wait_to(k + 12); chk("t3_glitch_held", {4'b0, held}, 5'b0);
    wait_to(k + 20);

    // Pulse of exactly 4 samples: accepted, one strobe
    k = cyc;
    btn_left = 1'b1;
    expect_strobe(k + 7, 4'b0010);
    wait_to(k + 4);  btn_left = 1'b0;
    wait_to(k + 10); chk("t3_pulse4_held", {4'b0, held}, 5'b1);
    wait_to(k + 11); chk("t3_pulse4_held_fall", {4'b0, held}, 5'b0);
    wait_to(k + 25);

    // Chatter: 1 high / 1 low for 20 cycles
    k = cyc;
    for (int i = 0; i < 20; i++) begin
      btn_left = (i % 2 == 0);
      if (i == 12) chk("t3_chatter_held_mid", {4'b0, held}, 5'b0);
      @(negedge clk);
    end
    btn_left = 1'b0;
    wait_to(k + 32);
    chk("t3_chatter_held_end", {4'b0, held}, 5'b0);

    // Conflict and reversal, right held throughout
    k = cyc;
    btn_up = 1'b1;
    btn_right = 1'b1;
    expect_strobe(k + 7, 4'b1000);
    expect_strobe(k + 17, 4'b1000);
    expect_strobe(k + 22, 4'b1000);
    expect_strobe(k + 7, 4'b0001);
    for (int c = 17; c <= 62; c += 5) expect_strobe(k + c, 4'b0001);
    expect_strobe(k + 42, 4'b0100);
    expect_strobe(k + 52, 4'b0100);
    expect_strobe(k + 57, 4'b0100);
    expect_strobe(k + 62, 4'b0100);
    wait_to(k + 20); btn_down = 1'b1;
    wait_to(k + 35); btn_up = 1'b0;
    wait_to(k + 40); chk("t4_held", {4'b0, held}, 5'b1);
    wait_to(k + 60); btn_down = 1'b0; btn_right = 1'b0;
    wait_to(k + 80);

    // Enable gating
    k = cyc;
    enable = 1'b0;
    btn_down = 1'b1;
    wait_to(k + 29); chk("t5_held_disabled", {4'b0, held}, 5'b1);
    wait_to(k + 30);
    enable = 1'b1;
    expect_strobe(k + 31, 4'b0100);
    expect_strobe(k + 41, 4'b0100);
    expect_strobe(k + 46, 4'b0100);
    wait_to(k + 44); btn_down = 1'b0;
    wait_to(k + 65);

    // Async reset mid-repeat
    k = cyc;
    btn_right = 1'b1;
    expect_strobe(k + 7, 4'b0001);
    expect_strobe(k + 17, 4'b0001);
    expect_strobe(k + 22, 4'b0001);
    expect_strobe(k + 27, 4'b0001);
    wait_to(k + 27);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {1'b0, up, down, left, right}, 5'b0);
    chk("t6_async_held", {4'b0, held}, 5'b0);
    wait_to(k + 29);
    rst_n = 1'b1;
    r = cyc;
    expect_strobe(r + 7, 4'b0001);
    expect_strobe(r + 17, 4'b0001);
    expect_strobe(r + 22, 4'b0001);
    wait_to(r + 20); btn_right = 1'b0;
    wait_to(r + 40);

    chk("queue_drained", 5'(exp_q.size()), 5'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
